mul_sched: RTL and testbench
============================

Name: mul_sched

Overview:
- Round-robin scheduler that shares one sequential `mul` unit among NREQ requesters.
- The `mul` unit has operands A/B of 8 bits, a 17-bit product O, and a start/fin handshake.
- The block accepts operand pairs, issues one start pulse per job and waits for fin. It returns the product to the owning requester with a one-hot valid.
- It guards against a hung multiplier with a timeout. It sits between client logic and the single `mul` instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TMO, 64, max cycles in WAIT before abort (1..255).

Ports:
- ck  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- req_i  input  NREQ  per-requester request level.
- a_i  input  8*NREQ  operand A; requester k uses bits [8k+7:8k].
- b_i  input  8*NREQ  operand B; same packing as a_i.
- ack_o  output  NREQ  one-hot, 1-cycle pulse: operands accepted.
- result_o  output  17  product (or 0 on error).
- rvalid_o  output  NREQ  one-hot, 1-cycle pulse: result_o valid for that requester.
- err_o  output  1  qualifies rvalid_o: 1 = timeout abort.
- busy_o  output  1  1 while state is WAIT.
- m_a  output  8  operand A to `mul`.
- m_b  output  8  operand B to `mul`.
- m_start  output  1  start pulse to `mul`.
- m_o  input  17  product from `mul`.
- m_fin  input  1  done from `mul`.

Behaviour:
- All outputs registered.
- Reset:
  - state=IDLE, rr_ptr=0, wait counter=0.
  - ack_o=0, rvalid_o=0, err_o=0, result_o=0, m_a=0, m_b=0, m_start=0, busy_o=0.
- States: IDLE, WAIT.
- IDLE, when any req_i bit is set at a posedge:
  - Select grant g = first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Registers: m_a<=a_i[g], m_b<=b_i[g], m_start<=1, ack_o[g]<=1, cnt<=0, state<=WAIT.
- IDLE with no request: hold; m_start=0, ack_o=0.
- WAIT, first cycle (m_start=1): m_fin is ignored. m_start and ack_o clear at the next edge.
- WAIT, later cycles:
  - m_a/m_b are held stable and cnt increments.
  - On m_fin=1: result_o<=m_o, rvalid_o[g]<=1, err_o<=0, rr_ptr<=(g+1) mod NREQ, state<=IDLE.
- Timeout:
  - If cnt reaches TMO with no fin: result_o<=0, rvalid_o[g]<=1, err_o<=1, rr_ptr advances as for fin, state<=IDLE.
  - m_fin in the same cycle as cnt==TMO takes priority: normal result.
- rvalid_o/err_o are 1-cycle pulses; result_o holds its value until the next completion.
- Requester obligations:
  - Keep req/a/b stable until ack.
  - Drop req the cycle after ack.
  - req still high when the scheduler returns to IDLE counts as a new request.
- Back-to-back: the edge that clears rvalid_o may also grant the next request. Throughput = mul latency + 2 cycles per job.
- Latency, req-to-ack: 1 edge from IDLE.
- Latency, fin-to-rvalid: 1 edge.
- m_fin while in IDLE (stray or late) is ignored: no rvalid, no state change.
- Reset mid-WAIT: job abandoned, no rvalid, rr_ptr=0. A later fin from `mul` is ignored.
- Product width: result_o = 17 bits zero-extended from `mul` O. Max 0xFF*0xFF = 0x0FE01.

Test Plan:
- Single job: req_i[0]=1, a=0x12, b=0x34, mul model latency 8 → ack_o=0001 one cycle after req; m_start pulse once; rvalid_o=0001, result_o=0x003A8, err_o=0.
- Fairness: req_i=1111 held, distinct operands per requester → ack order 0,1,2,3,0. Each rvalid carries that requester's product. Gap from rvalid to next ack is 0 cycles.
- Priority pointer: serve requester 2, then req_i=0011 → grant 0 (search wraps from rr_ptr=3), then 1.
- Timeout: TMO=16, mul model never asserts fin → rvalid_o on 17th WAIT cycle with err_o=1, result_o=0. Next request is served normally.
- Boundary: a=0xFF, b=0xFF → result_o=0x0FE01. Stray m_fin pulse in IDLE → no rvalid, state unchanged.
- Reset mid-WAIT: rst pulsed during WAIT → all outputs 0 next edge. Subsequent fin ignored; a new req_i[3] job is granted first, since rr_ptr=0 and only 3 requests.

Source files
------------

// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler that shares one sequential 8x8 multiplier
// among NREQ requesters.
//
// A request is accepted in IDLE and acknowledged with a one-hot ack_o pulse. The
// operands are driven to the multiplier together with a single m_start pulse. The
// scheduler then waits for m_fin and returns the product with a one-hot rvalid_o
// pulse to the requester that owns the job. A hung multiplier is aborted after TMO
// WAIT cycles, and that abort is reported as rvalid_o with err_o=1 and result_o=0.
//
// Ports:
//   ck        clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   req_i     per-requester request level
//   a_i, b_i  packed operands, requester k uses bits [8k+7:8k]
//   ack_o     one-hot 1-cycle pulse, operands accepted
//   result_o  product of the last completed job (0 after a timeout)
//   rvalid_o  one-hot 1-cycle pulse, result_o valid for that requester
//   err_o     qualifies rvalid_o, 1 = timeout abort
//   busy_o    high while a job is outstanding (state WAIT)
//   m_a, m_b  operands to the multiplier, held stable during WAIT
//   m_start   start pulse to the multiplier
//   m_o       product from the multiplier
//   m_fin     done from the multiplier
module mul_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TMO  = 64
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] a_i,
  input  logic [8*NREQ-1:0] b_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [16:0]       result_o,
  output logic [NREQ-1:0]   rvalid_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [7:0]        m_a,
  output logic [7:0]        m_b,
  output logic              m_start,
  input  logic [16:0]       m_o,
  input  logic              m_fin
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   rr_ptr, rr_ptr_n;
  logic [PW-1:0]   owner, owner_n;
  logic [7:0]      cnt, cnt_n;
  logic [NREQ-1:0] ack_n, rvalid_n;
  logic [16:0]     result_n;
  logic            err_n, start_n;
  logic [7:0]      m_a_n, m_b_n;

  logic            gnt_found;
  logic [PW-1:0]   gnt;
  logic [PW-1:0]   owner_inc;
  logic [PW:0]     sum;

  // Round-robin search: the first set request at or above rr_ptr, wrapping modulo
  // NREQ. The sum has an extra bit so that the wrap also works when NREQ is not a
  // power of two.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    sum       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      if (!gnt_found && req_i[sum[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt       = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    owner_n  = owner;
    cnt_n    = cnt;
    ack_n    = '0;
    rvalid_n = '0;
    err_n    = 1'b0;
    start_n  = 1'b0;
    result_n = result_o;
    m_a_n    = m_a;
    m_b_n    = m_b;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          m_a_n      = a_i[8*gnt +: 8];
          m_b_n      = b_i[8*gnt +: 8];
          start_n    = 1'b1;
          ack_n[gnt] = 1'b1;
          owner_n    = gnt;
          cnt_n      = '0;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt + 8'd1;
        // m_start is still high only in the first WAIT cycle, so it masks m_fin
        // there. m_fin takes priority over a timeout in the same cycle.
        if (!m_start && m_fin) begin
          result_n        = m_o;
          rvalid_n[owner] = 1'b1;
          rr_ptr_n        = owner_inc;
          cnt_n           = '0;
          state_n         = IDLE;
        end else if (cnt == 8'(TMO)) begin
          result_n        = '0;
          rvalid_n[owner] = 1'b1;
          err_n           = 1'b1;
          rr_ptr_n        = owner_inc;
          cnt_n           = '0;
          state_n         = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      cnt      <= '0;
      ack_o    <= '0;
      rvalid_o <= '0;
      err_o    <= 1'b0;
      result_o <= '0;
      m_a      <= '0;
      m_b      <= '0;
      m_start  <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      cnt      <= cnt_n;
      ack_o    <= ack_n;
      rvalid_o <= rvalid_n;
      err_o    <= err_n;
      result_o <= result_n;
      m_a      <= m_a_n;
      m_b      <= m_b_n;
      m_start  <= start_n;
    end
  end

  assign busy_o = (state == WAIT);

endmodule

// File: tb/tb_mul_sched.sv
module tb_mul_sched;
  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [3:0]  ack_o, rvalid_o;
  logic [16:0] result_o;
  logic        err_o, busy_o;
  logic [7:0]  m_a, m_b;
  logic        m_start;
  logic [16:0] m_o = '0;
  logic        m_fin = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 ck = ~ck;

  mul_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
    .ck(ck), .rst(rst), .req_i(req_i), .a_i(a_i), .b_i(b_i),
    .ack_o(ack_o), .result_o(result_o), .rvalid_o(rvalid_o), .err_o(err_o),
    .busy_o(busy_o), .m_a(m_a), .m_b(m_b), .m_start(m_start),
    .m_o(m_o), .m_fin(m_fin)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Multiplier model: latches the operands on m_start and raises m_fin for one
  // cycle 'left' cycles later. 'hang' suppresses fin, 'stray' injects a spurious fin.
  int          lat = 4;
  bit          hang = 0, rand_lat = 0, stray = 0;
  bit          pending = 0;
  int          left = 0;
  logic [16:0] prod = '0;

  always @(posedge ck) begin
    #2;
    m_fin = 1'b0;
    if (stray) begin
      m_fin = 1'b1;
      m_o   = 17'($urandom);
      stray = 0;
    end else if (m_start) begin
      left    = rand_lat ? int'($urandom_range(1, 18)) : lat;
      pending = !hang;
      prod    = 17'(m_a) * 17'(m_b);
    end else if (pending) begin
      left--;
      if (left == 0) begin
        m_fin   = 1'b1;
        m_o     = prod;
        pending = 0;
      end
    end
  end

  // Reference model. This block is evaluated at the falling edge. First it compares
  // what the DUT shows with the expected values. Then it derives the expected values
  // for the next cycle from the inputs that are currently applied.
  logic [3:0]  e_ack = '0, e_rv = '0;
  logic        e_err = 0, e_busy = 0, e_start = 0;
  logic [16:0] e_res = '0;
  logic [7:0]  e_ma = '0, e_mb = '0;
  bit          s_busy = 0;
  int          s_rr = 0, s_own = 0, s_age = 0;
  logic [16:0] s_prod = '0;

  always @(negedge ck) begin
    chk("ack", 32'(ack_o), 32'(e_ack));
    chk("rvalid", 32'(rvalid_o), 32'(e_rv));
    chk("err", 32'(err_o), 32'(e_err));
    chk("result", 32'(result_o), 32'(e_res));
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("m_start", 32'(m_start), 32'(e_start));
    chk("m_a", 32'(m_a), 32'(e_ma));
    chk("m_b", 32'(m_b), 32'(e_mb));
    if (rst) begin
      e_ack = '0; e_rv = '0; e_err = 0; e_res = '0; e_busy = 0; e_start = 0;
      e_ma = '0; e_mb = '0; s_busy = 0; s_rr = 0;
    end else begin
      e_ack = '0; e_rv = '0; e_err = 0; e_start = 0;
      if (!s_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (s_rr + k) % NREQ;
          if (!s_busy && req_i[j]) begin
            logic [7:0] aa, bb;
            aa = a_i[8*j +: 8];
            bb = b_i[8*j +: 8];
            e_ack[j] = 1'b1; e_start = 1; e_ma = aa; e_mb = bb;
            s_prod = 17'(aa) * 17'(bb);
            s_busy = 1; s_own = j; s_age = 1;
          end
        end
      end else if (s_age >= 2 && m_fin) begin
        e_rv[s_own] = 1'b1; e_res = s_prod;
        s_rr = (s_own + 1) % NREQ; s_busy = 0;
      end else if (s_age - 1 == TMO) begin
        e_rv[s_own] = 1'b1; e_res = '0; e_err = 1;
        s_rr = (s_own + 1) % NREQ; s_busy = 0;
      end else begin
        s_age++;
      end
      e_busy = s_busy;
    end
  end

  task automatic tick();
    @(posedge ck);
    #2;
  endtask

  task automatic wait_ack(output logic [3:0] v, output int cyc);
    cyc = 0; v = '0;
    for (int i = 0; i < 64; i++) begin
      tick(); cyc++;
      if (ack_o != 0) begin v = ack_o; return; end
    end
    checks++; failures++;
    $display("FAIL ack_wait expired actual=none required=ack t=%0t", $time);
  endtask

  task automatic wait_rv(output int cyc, output int starts);
    cyc = 0; starts = 0;
    for (int i = 0; i < 64; i++) begin
      tick(); cyc++;
      if (m_start) starts++;
      if (rvalid_o != 0) return;
    end
    checks++; failures++;
    $display("FAIL rvalid_wait expired actual=none required=rvalid t=%0t", $time);
  endtask

  task automatic do_reset();
    rst = 1; req_i = '0;
    repeat (2) tick();
    rst = 0;
  endtask

  initial begin
    logic [3:0] v;
    int c, s;
    repeat (3) tick();
    rst = 0;
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_result", 32'(result_o), 0);

    // Single job
    lat = 8; a_i[7:0] = 8'h12; b_i[7:0] = 8'h34; req_i = 4'b0001;
    wait_ack(v, c);
    chk("single_ack", 32'(v), 32'h1);
    chk("single_ack_lat", 32'(c), 1);
    chk("single_start", 32'(m_start), 1);
    req_i = '0;
    wait_rv(c, s);
    chk("single_rv_lat", 32'(c), 9);
    chk("single_extra_starts", 32'(s), 0);
    chk("single_rv", 32'(rvalid_o), 32'h1);
    chk("single_result", 32'(result_o), 32'h3A8);
    chk("single_err", 32'(err_o), 0);

    // Fairness, all requests held
    do_reset();
    lat = 3;
    a_i = {8'hd4, 8'hc3, 8'hb2, 8'ha1};
    b_i = {8'h0f, 8'h1e, 8'h2d, 8'h3c};
    req_i = 4'hf;
    for (int g = 0; g < 5; g++) begin
      wait_ack(v, c);
      chk("fair_order", 32'(v), 32'(1 << (g % 4)));
      if (g > 0) chk("fair_gap", 32'(c), 1);
      if (g == 4) req_i = '0;
      wait_rv(c, s);
      chk("fair_rv", 32'(rvalid_o), 32'(1 << (g % 4)));
    end

    // Priority pointer
    req_i = 4'b0100;
    wait_ack(v, c);
    chk("prio_first", 32'(v), 32'h4);
    req_i = '0;
    wait_rv(c, s);
    req_i = 4'b0011;
    wait_ack(v, c);
    chk("prio_wrap", 32'(v), 32'h1);
    req_i = 4'b0010;
    wait_rv(c, s);
    wait_ack(v, c);
    chk("prio_next", 32'(v), 32'h2);
    chk("prio_next_gap", 32'(c), 1);
    req_i = '0;
    wait_rv(c, s);

    // Timeout
    hang = 1; req_i = 4'b0010;
    wait_ack(v, c);
    chk("tmo_ack", 32'(v), 32'h2);
    req_i = '0;
    wait_rv(c, s);
    chk("tmo_lat", 32'(c), 17);
    chk("tmo_err", 32'(err_o), 1);
    chk("tmo_result", 32'(result_o), 0);
    chk("tmo_rv", 32'(rvalid_o), 32'h2);
    hang = 0; lat = 5;
    a_i[7:0] = 8'h05; b_i[7:0] = 8'h07; req_i = 4'b0001;
    wait_ack(v, c);
    req_i = '0;
    wait_rv(c, s);
    chk("post_tmo_err", 32'(err_o), 0);
    chk("post_tmo_result", 32'(result_o), 32'h23);

    // Boundary operands
    a_i[7:0] = 8'hff; b_i[7:0] = 8'hff; req_i = 4'b0001;
    wait_ack(v, c);
    req_i = '0;
    wait_rv(c, s);
    chk("max_result", 32'(result_o), 32'h0FE01);

    // Stray fin while idle
    tick();
    stray = 1;
    repeat (4) begin
      tick();
      chk("stray_rv", 32'(rvalid_o), 0);
      chk("stray_busy", 32'(busy_o), 0);
    end

    // Reset in the middle of WAIT
    lat = 10; req_i = 4'b0010;
    wait_ack(v, c);
    req_i = '0;
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_rv", 32'(rvalid_o), 0);
    chk("midrst_start", 32'(m_start), 0);
    chk("midrst_m_a", 32'(m_a), 0);
    chk("midrst_result", 32'(result_o), 0);
    repeat (12) begin
      tick();
      chk("midrst_stale_rv", 32'(rvalid_o), 0);
    end
    req_i = 4'b1000;
    wait_ack(v, c);
    chk("midrst_grant", 32'(v), 32'h8);
    chk("midrst_grant_lat", 32'(c), 1);
    req_i = '0;
    wait_rv(c, s);
    chk("midrst_job_err", 32'(err_o), 0);

    // Randomized traffic
    rand_lat = 1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      for (int k = 0; k < NREQ; k++) begin
        if (req_i[k] && ack_o[k]) begin
          req_i[k] = 1'b0;
        end else if (!req_i[k] && $urandom_range(0, 3) == 0) begin
          a_i[8*k +: 8] = 8'($urandom);
          b_i[8*k +: 8] = 8'($urandom);
          req_i[k] = 1'b1;
        end
      end
    end
    rst = 0; req_i = '0; rand_lat = 0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
